ack_resp: RTL

Responder end of the request/ack bus handshake. Up to two requesters each hold a level request until they see a one-cycle `ack` that doubles as their data-latch strobe. This block arbitrates between the requesters, inserts programmable wait and recovery states, and drives the one-hot ack plus memory output-enable and write strobes. It sits between the object/blitter-side requester pipes and the external memory control.

---
 rtl/ack_resp.sv | 120 ++++++++++++
 1 files changed

// File: rtl/ack_resp.sv
// Responder side of the req/ack bus handshake: round-robin arbitration between two
// requesters, programmable wait/recovery, registered one-hot ack and memory strobes.
module ack_resp #(
    parameter int WS_W = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [1:0]      req,
    input  logic [1:0]      rw,
    input  logic [WS_W-1:0] wait_cfg,
    input  logic [WS_W-1:0] rec_cfg,
    output logic [1:0]      gnt,
    output logic [1:0]      ack,
    output logic            oe,
    output logic            we,
    output logic            busy
);

    // state   | meaning
    // S_IDLE  | sampling req, nothing granted
    // S_WAIT  | granted, counting wait states
    // S_ACK   | single ack / data-latch cycle
    // S_RECOV | bus recovery before next grant
    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK, S_RECOV} state_t;

    state_t          state_q, state_d;
    logic [WS_W-1:0] cnt_q, cnt_d;
    logic [WS_W-1:0] rcfg_q, rcfg_d;
    logic            rd_q, rd_d;
    logic            last_q, last_d;
    logic [1:0]      gnt_q, gnt_d;
    logic [1:0]      ack_q, ack_d;
    logic            oe_q, oe_d;
    logic            we_q, we_d;
    logic            busy_q, busy_d;
    logic            win;
    logic [1:0]      win_oh;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rcfg_d  = rcfg_q;
        rd_d    = rd_q;
        last_d  = last_q;
        win     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (req != 2'b00) begin
                    if (req == 2'b11) win = ~last_q;
                    else              win = req[1];
                    last_d  = win;
                    rd_d    = rw[win];
                    cnt_d   = wait_cfg;
                    rcfg_d  = rec_cfg;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (cnt_q == '0) state_d = S_ACK;
                else             cnt_d   = cnt_q - WS_W'(1);
            end
            S_ACK: begin
                if (rcfg_q != '0) begin
                    state_d = S_RECOV;
                    cnt_d   = rcfg_q;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RECOV: begin
                // guard against 0 so the counter can never wrap
                if (cnt_q != '0) cnt_d = cnt_q - WS_W'(1);
                if (cnt_q <= WS_W'(1)) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // outputs are decoded from the next state so they appear registered
        win_oh = last_d ? 2'b10 : 2'b01;
        gnt_d  = ((state_d == S_WAIT) || (state_d == S_ACK)) ? win_oh : 2'b00;
        ack_d  = (state_d == S_ACK) ? win_oh : 2'b00;
        oe_d   = ((state_d == S_WAIT) || (state_d == S_ACK)) && rd_d;
        we_d   = (state_d == S_ACK) && !rd_d;
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            rcfg_q  <= '0;
            rd_q    <= 1'b0;
            last_q  <= 1'b1;
            gnt_q   <= 2'b00;
            ack_q   <= 2'b00;
            oe_q    <= 1'b0;
            we_q    <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rcfg_q  <= rcfg_d;
            rd_q    <= rd_d;
            last_q  <= last_d;
            gnt_q   <= gnt_d;
            ack_q   <= ack_d;
            oe_q    <= oe_d;
            we_q    <= we_d;
            busy_q  <= busy_d;
        end
    end

    assign gnt  = gnt_q;
    assign ack  = ack_q;
    assign oe   = oe_q;
    assign we   = we_q;
    assign busy = busy_q;

endmodule
